uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter with a valid/ready byte interface, runtime-selectable frame format (data length, parity, 1 or 2 stop bits) and configurable oversampling. It is the next generation of the team's fixed-8N1 transmitter and sits between the result/interface logic and the serial pin. Bit timing comes from the shared baud-tick generator (one i_tick per 1/OVS bit period).

Parameters:
DBIT, 8, maximum data bits per frame (legal 5..16); sets i_data width
OVS, 16, i_tick pulses per serial bit (legal 4..32)
NBW, $clog2(DBIT+1), width of i_nbits (derived; do not override)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_tick  input  1  oversampling tick, one-cycle pulse
i_valid  input  1  frame request; accepted when i_valid & o_ready
i_data  input  DBIT  payload, LSB transmitted first
i_nbits  input  NBW  data bits this frame; 0 or >DBIT is treated as DBIT
i_par  input  2  00 none, 01 even, 10 odd, 11 none
i_stop2  input  1  0 = one stop bit, 1 = two stop bits
o_ready  output  1  high only in IDLE
o_busy  output  1  high in every state except IDLE
o_done_tx  output  1  one-cycle pulse when the final stop bit completes
o_tx  output  1  serial line, registered, idle high

Behaviour:
- Clocking: single clock i_clk; synchronous, active-high reset i_rst.
- Reset: state IDLE; o_tx=1; o_ready=1; o_busy=0; o_done_tx=0; all counters and the shift register cleared.
- Acceptance: on the edge where i_valid & o_ready, capture i_data, i_nbits (clamped), i_par and i_stop2 into frame registers. Later changes to the inputs do not affect the frame in flight. The next state is START.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- o_tx is registered. It is 0 from the first edge after acceptance. It holds each bit value for exactly OVS i_tick pulses, counted by tick counter s (width $clog2(OVS)).
- START: o_tx=0. When s==OVS-1 on a tick, clear s and n, then go to DATA.
- DATA: o_tx=shift[0]. When s==OVS-1 on a tick, clear s and shift right. If n==nbits-1, go to PARITY (parity enabled and par is 01 or 10) else STOP; otherwise n++.
- PARITY: o_tx = XOR of the transmitted data bits (even), or its inverse (odd). Duration OVS ticks, then STOP.
- STOP: o_tx=1. Duration OVS ticks for one stop bit, 2*OVS ticks for two. A stop-half counter is cleared on entry.
  - On the final tick: o_done_tx=1 for that cycle and state_next=IDLE.
  - o_done_tx is combinational from state, tick and counters.
- Back-to-back: o_ready asserts the cycle after the done pulse. A frame accepted then starts its start bit with no extra idle bit; minimum idle gap is 1 clock.
- i_tick while IDLE is ignored. Ticks are not required to be aligned to acceptance, so the first bit may be up to one tick period short of OVS ticks in clock terms. The tick count is always exact.
- i_valid while busy is ignored; no queuing.
- Reset mid-frame: the next edge forces IDLE and o_tx=1. No done pulse; the partial frame is dropped.
- Simultaneous i_rst and i_valid: reset wins; nothing is accepted.
- Width rules: n has width NBW. Parity is accumulated only over the nbits data bits actually sent; higher i_data bits are ignored.

Optional Feature:
UART_TX_PARITY_EN
- Defined: i_par is honoured and the PARITY state is built.
- Undefined: the PARITY state and parity logic are not generated. i_par is ignored, and frames are always no-parity with DATA going directly to STOP. The port stays present so instantiations are identical.

Test Plan:
- DBIT=8, OVS=16, nbits=8, par=00, stop2=0, data=8'hA5 -> o_tx: 0, bits 1,0,1,0,0,1,0,1, then 1; each bit 16 ticks; o_done_tx pulses once after 160 ticks; o_ready=1 the next cycle.
- nbits=5, par=01 (macro defined), data=8'hFF -> 5 ones then parity bit 1 (five ones, even); frame is 8 bits x 16 ticks; bits 7:5 never appear. With the macro undefined, the same stimulus gives 7 bits and no parity bit.
- par=10, stop2=1, nbits=8, data=8'h00 -> parity bit 1; stop high for 32 ticks before the done pulse.
- i_rst asserted at tick 70 of a frame -> o_tx=1 and o_ready=1 on the next edge, no o_done_tx pulse; a new frame then transmits correctly.
- i_valid held high continuously with data 8'h01 then 8'h80 -> two complete frames separated by 1 idle clock; second data captured only at the second o_ready; i_data changed mid-frame has no effect.
- i_nbits=0 and i_nbits=9 (DBIT=8) -> both transmit 8 data bits.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with a valid/ready byte interface, runtime frame
// format (data length, parity, one or two stop bits) and OVS ticks per bit.
// Optional feature macro: UART_TX_PARITY_EN builds the PARITY state and honours
// i_par; without it every frame is sent without a parity bit.
module uart_tx_cfg #(
    parameter int DBIT = 8,
    parameter int OVS  = 16,
    parameter int NBW  = $clog2(DBIT + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic            i_valid,
    input  logic [DBIT-1:0] i_data,
    input  logic [NBW-1:0]  i_nbits,
    input  logic [1:0]      i_par,
    input  logic            i_stop2,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_done_tx,
    output logic            o_tx
);

    localparam int SW = $clog2(OVS);
    localparam logic [SW-1:0]  S_LAST = SW'(OVS - 1);
    localparam logic [NBW-1:0] NB_MAX = NBW'(DBIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [SW-1:0]   s;
    logic [NBW-1:0]  n;
    logic [DBIT-1:0] shift;
    logic [NBW-1:0]  nbits_r;
    logic            stop2_r;
    logic            half;
    logic            tx;
    logic            ready;
    logic            busy;
    logic [NBW-1:0]  nbits_clamped;
    logic            last_data;

`ifdef UART_TX_PARITY_EN
    logic [1:0] par_r;
    logic       par_acc;
    logic       parity_on;
    logic       parity_bit;

    // Parity covers only the bits actually shifted out; odd parity inverts the running XOR.
    always_comb begin
        parity_on  = (par_r == 2'b01) || (par_r == 2'b10);
        parity_bit = par_acc ^ shift[0] ^ par_r[1];
    end
`else
    logic unused_par;
    assign unused_par = ^i_par;
`endif

    // A length of zero or beyond the data width means a full-width frame.
    always_comb begin
        nbits_clamped = i_nbits;
        if ((i_nbits == '0) || (i_nbits > NB_MAX)) begin
            nbits_clamped = NB_MAX;
        end
        last_data = (n == (nbits_r - 1'b1));
    end

    // Frame sequencer: every bit lasts exactly OVS ticks; o_tx always shows the bit in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            shift   <= '0;
            nbits_r <= '0;
            stop2_r <= 1'b0;
            half    <= 1'b0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r   <= 2'b00;
            par_acc <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shift   <= i_data;
                        nbits_r <= nbits_clamped;
                        stop2_r <= i_stop2;
`ifdef UART_TX_PARITY_EN
                        par_r   <= i_par;
                        par_acc <= 1'b0;
`endif
                        s       <= '0;
                        n       <= '0;
                        half    <= 1'b0;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            tx    <= shift[0];
                            state <= DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            shift <= shift >> 1;
`ifdef UART_TX_PARITY_EN
                            par_acc <= par_acc ^ shift[0];
`endif
                            if (last_data) begin
`ifdef UART_TX_PARITY_EN
                                if (parity_on) begin
                                    tx    <= parity_bit;
                                    state <= PARITY;
                                end else begin
                                    tx    <= 1'b1;
                                    half  <= 1'b0;
                                    state <= STOP;
                                end
`else
                                tx    <= 1'b1;
                                half  <= 1'b0;
                                state <= STOP;
`endif
                            end else begin
                                n  <= n + 1'b1;
                                tx <= shift[1];
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (i_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            tx    <= 1'b1;
                            half  <= 1'b0;
                            state <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            if (!stop2_r || half) begin
                                ready <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                half <= 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_done_tx = (state == STOP) && i_tick && (s == S_LAST) && (!stop2_r || half);
    assign o_ready   = ready;
    assign o_busy    = busy;
    assign o_tx      = tx;

endmodule
